debug_step_ctrl: RTL and testbench

DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

---
 rtl/debug_pkg.sv | 16 +
 rtl/press_classifier.sv | 53 +++++
 rtl/debug_step_ctrl.sv | 105 ++++++++++
 tb/tb_debug_step_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug single-step controller.
package debug_pkg;

  // Controller states; HALT/WAIT hold the pipeline, STEP releases it for one cycle.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // 1 s at 50 MHz.
  localparam int unsigned LONG_CYCLES_DEF    = 50_000_000;
  localparam int unsigned RETIRE_TIMEOUT_DEF = 16;

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button presses into one-cycle SHORT and LONG events.
module press_classifier
  import debug_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_value,
  output logic short_evt,
  output logic long_evt
);

  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);

  logic          held;
  logic          long_done;
  logic [CW-1:0] hold_cnt;
  logic          press_start;
  logic          release_evt;
  logic          at_long;

  // Decode key strobes and event conditions.
  always_comb begin
    press_start = key_flag & ~key_value;
    release_evt = key_flag & key_value;
    at_long     = (hold_cnt == CW'(LONG_CYCLES));
    // Counter saturates at LONG_CYCLES; long_done keeps the event to one pulse.
    long_evt    = held & at_long & ~long_done;
    short_evt   = release_evt & held & ~at_long;
  end

  // Hold tracking: press-start restarts the count, release ends the press.
  always_ff @(posedge clk) begin
    if (rst) begin
      held      <= 1'b0;
      long_done <= 1'b0;
      hold_cnt  <= '0;
    end else if (press_start) begin
      held      <= 1'b1;
      long_done <= 1'b0;
      hold_cnt  <= '0;
    end else if (release_evt) begin
      held      <= 1'b0;
      hold_cnt  <= '0;
    end else if (held) begin
      if (!at_long) hold_cnt <= hold_cnt + 1'b1;
      if (long_evt) long_done <= 1'b1;
    end
  end

endmodule

// File: rtl/debug_step_ctrl.sv
// Button-driven run/halt/single-step controller for a CPU pipeline.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned LONG_CYCLES    = LONG_CYCLES_DEF,
  parameter int unsigned RETIRE_TIMEOUT = RETIRE_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_flag,
  input  logic        key_value,
  input  logic        retire,
  output logic        stall,
  output logic        step_pulse,
  output logic        halted,
  output logic        led_halt,
  output logic [15:0] step_cnt,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(RETIRE_TIMEOUT + 1);

  state_t        state;
  state_t        state_nxt;
  logic          short_evt;
  logic          long_evt;
  logic [TW-1:0] wait_cnt;
  logic [15:0]   step_cnt_q;
  logic          count_step;
  logic          set_err;

  press_classifier #(
    .LONG_CYCLES(LONG_CYCLES)
  ) u_press (
    .clk      (clk),
    .rst      (rst),
    .key_flag (key_flag),
    .key_value(key_value),
    .short_evt(short_evt),
    .long_evt (long_evt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next-state logic; events outside RUN/HALT are dropped.
  always_comb begin
    state_nxt  = state;
    count_step = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_RUN:  if (long_evt) state_nxt = ST_HALT;
      ST_HALT: begin
        if (short_evt)     state_nxt = ST_STEP;
        else if (long_evt) state_nxt = ST_RUN;
      end
      ST_STEP: begin
        if (retire) begin
          state_nxt  = ST_HALT;
          count_step = 1'b1;
        end else begin
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // wait_cnt == RETIRE_TIMEOUT-1 is the last permitted WAIT cycle.
        if (retire) begin
          state_nxt  = ST_HALT;
          count_step = 1'b1;
        end else if (wait_cnt == TW'(RETIRE_TIMEOUT - 1)) begin
          state_nxt  = ST_HALT;
          set_err    = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Wait timer, retired-step counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      step_cnt_q  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_STEP)      wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (count_step) step_cnt_q  <= step_cnt_q + 16'd1;
      if (set_err)    timeout_err <= 1'b1;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    stall      = (state == ST_HALT) || (state == ST_WAIT);
    step_pulse = (state == ST_STEP);
    halted     = (state != ST_RUN);
    led_halt   = halted;
    step_cnt   = step_cnt_q;
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed self-checking bench for debug_step_ctrl (LONG_CYCLES=8, RETIRE_TIMEOUT=4).
module tb_debug_step_ctrl;

  localparam int unsigned LC = 8;
  localparam int unsigned RT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_flag;
  logic        key_value;
  logic        retire;
  logic        stall;
  logic        step_pulse;
  logic        halted;
  logic        led_halt;
  logic [15:0] step_cnt;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  debug_step_ctrl #(
    .LONG_CYCLES   (LC),
    .RETIRE_TIMEOUT(RT)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .key_flag   (key_flag),
    .key_value  (key_value),
    .retire     (retire),
    .stall      (stall),
    .step_pulse (step_pulse),
    .halted     (halted),
    .led_halt   (led_halt),
    .step_cnt   (step_cnt),
    .timeout_err(timeout_err)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    key_flag = 1'b1; key_value = 1'b0;
    tick();
    key_flag = 1'b0;
  endtask

  task automatic release_key();
    key_flag = 1'b1; key_value = 1'b1;
    tick();
    key_flag = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},  32'(stall),       32'd0);
    check({tag, "_pulse"},  32'(step_pulse),  32'd0);
    check({tag, "_halted"}, 32'(halted),      32'd0);
    check({tag, "_led"},    32'(led_halt),    32'd0);
    check({tag, "_cnt"},    32'(step_cnt),    32'd0);
    check({tag, "_err"},    32'(timeout_err), 32'd0);
  endtask

  // Short press whose step retires in the STEP cycle (3 cycles, ends in HALT).
  task automatic step_retire_now();
    key_flag = 1'b1; key_value = 1'b0;
    tick();
    key_flag = 1'b1; key_value = 1'b1;
    tick();
    key_flag = 1'b0;
    check("fast_step_pulse", 32'(step_pulse), 32'd1);
    retire = 1'b1;
    tick();
    retire = 1'b0;
  endtask

  // Hold the button ten cycles, then release.
  task automatic long_press();
    press();
    for (int i = 0; i < 10; i++) tick();
    release_key();
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #100_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_long;
    int long_at;
    int n;
    int pulses;

    rst = 1'b1; key_flag = 1'b0; key_value = 1'b1; retire = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // retire in RUN does nothing
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("run_retire_cnt", 32'(step_cnt), 32'd0);
    check("run_retire_halted", 32'(halted), 32'd0);

    // Long press: LONG once when counter hits 8 (ninth sample after press edge)
    press();
    n_long = 0;
    long_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (u_dut.u_press.long_evt) begin
        n_long++;
        long_at = i;
      end
      if (i == 9) check("long_halted_next", 32'(halted), 32'd1);
      tick();
    end
    check("long_count", 32'(n_long), 32'd1);
    check("long_cycle", 32'(long_at), 32'd8);
    check("long_stall", 32'(stall), 32'd1);
    check("long_led", 32'(led_halt), 32'd1);
    key_flag = 1'b1; key_value = 1'b1;
    #1;
    check("long_release_no_short", 32'(u_dut.u_press.short_evt), 32'd0);
    tick();
    key_flag = 1'b0;
    check("long_release_pulse", 32'(step_pulse), 32'd0);
    check("long_release_stall", 32'(stall), 32'd1);

    // Short press in HALT: step, retire in second WAIT cycle
    press();
    tick();
    tick();
    key_flag = 1'b1; key_value = 1'b1;
    #1;
    check("short_evt", 32'(u_dut.u_press.short_evt), 32'd1);
    tick();
    key_flag = 1'b0;
    check("step_pulse", 32'(step_pulse), 32'd1);
    check("step_stall", 32'(stall), 32'd0);
    check("step_halted", 32'(halted), 32'd1);
    tick();
    check("wait1_pulse", 32'(step_pulse), 32'd0);
    check("wait1_stall", 32'(stall), 32'd1);
    tick();
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("retire_cnt", 32'(step_cnt), 32'd1);
    check("retire_stall", 32'(stall), 32'd1);
    check("retire_err", 32'(timeout_err), 32'd0);

    // retire in HALT does nothing
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("halt_retire_cnt", 32'(step_cnt), 32'd1);
    check("halt_retire_pulse", 32'(step_pulse), 32'd0);

    // Timeout: four WAIT cycles, error appears on the fifth edge after STEP
    press();
    release_key();
    check("to_step_pulse", 32'(step_pulse), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout_err && n < 10);
    check("timeout_latency", 32'(n), 32'd5);
    check("timeout_err", 32'(timeout_err), 32'd1);
    check("timeout_cnt", 32'(step_cnt), 32'd1);
    check("timeout_stall", 32'(stall), 32'd1);

    // Short press during WAIT is discarded
    press();
    release_key();
    tick();
    press();
    release_key();
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("wait_press_cnt", 32'(step_cnt), 32'd2);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (step_pulse) pulses++;
      tick();
    end
    check("wait_press_no_step", 32'(pulses), 32'd0);
    check("wait_press_stall", 32'(stall), 32'd1);
    check("err_sticky", 32'(timeout_err), 32'd1);

    // Wrap: preload near the top, then real retired steps
    force u_dut.step_cnt_q = 16'hFFFD;
    tick();
    release u_dut.step_cnt_q;
    tick();
    check("preload", 32'(step_cnt), 32'h0000FFFD);
    step_retire_now();
    step_retire_now();
    check("cnt_ffff", 32'(step_cnt), 32'h0000FFFF);
    step_retire_now();
    check("cnt_wrap", 32'(step_cnt), 32'h00000000);

    // LONG in HALT returns to RUN, another LONG halts again
    long_press();
    check("long_to_run", 32'(halted), 32'd0);
    check("long_to_run_stall", 32'(stall), 32'd0);
    long_press();
    check("long_to_halt", 32'(halted), 32'd1);

    // Reset during WAIT with button held
    press();
    release_key();
    tick();
    key_flag = 1'b1; key_value = 1'b0;
    tick();
    key_flag = 1'b0;
    check("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midwait_rst");
    key_flag = 1'b1; key_value = 1'b1;
    #1;
    check("rst_release_no_short", 32'(u_dut.u_press.short_evt), 32'd0);
    tick();
    key_flag = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_long", 32'(halted), 32'd0);
    check("rst_no_pulse", 32'(step_pulse), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
